nrisc_mem_dump: RTL and testbench
=================================

// Module: nrisc_mem_dump
// PURPOSE
//  Debug read-out engine for the nRisc core: on halt, walks data memory over a read port and streams each byte out on
//  a valid/ready byte channel. Replaces backdoor memory inspection with a synthesizable port.
//  Sits beside DataMem on a second, read-only port; the sink is a UART/trace FIFO or bench monitor.
// PARAMETERS
//  ADDR_W      8  data-memory address width
//  DATA_W      8  data-memory word width (equals stream byte width)
//  BASE_ADDR   0  first address dumped
//  DUMP_COUNT  5  words dumped, 1..2**ADDR_W
// PORTS
//  CLK         in   1       clock, all logic on posedge
//  RESET       in   1       synchronous, active-high reset
//  halt_i      in   1       core halted (HALT decoded, instruction == 8'h00)
//  mem_addr_o  out  ADDR_W  data-memory read address
//  mem_rd_o    out  1       read strobe, high in READ only
//  mem_data_i  in   DATA_W  read data, combinational from mem_addr_o (same cycle)
//  dout_data   out  DATA_W  stream byte
//  dout_valid  out  1       stream byte valid
//  dout_ready  in   1       sink accepts byte
//  dout_last   out  1       qualifies the final byte of the dump
//  busy_o      out  1       dump in progress (READ/SEND/SUM)
//  done_o      out  1       dump complete, sticky until RESET
// BEHAVIOUR
//  Reset: state IDLE; mem_addr_o=BASE_ADDR; mem_rd_o, dout_valid, dout_last, busy_o, done_o = 0; dout_data=0; sum=0.
//  FSM: IDLE -> READ when halt_i=1 (level, sampled at posedge).
//   READ: mem_rd_o=1; dout_data<=mem_data_i, dout_valid<=1, sum<=sum+mem_data_i (mod 2**DATA_W); -> SEND.
//   SEND: dout_valid held, dout_data stable until dout_valid&&dout_ready at posedge; then dout_valid<=0 and:
//     idx < DUMP_COUNT-1: mem_addr_o<=mem_addr_o+1 (wraps mod 2**ADDR_W), idx++ -> READ.
//     final word: -> SUM if checksum compiled in, else -> DONE.
//   SUM: dout_data=sum, dout_valid=1, dout_last=1; on handshake -> DONE.
//   DONE: done_o=1, all stream outputs 0; halt_i ignored; exit only via RESET.
//  Latency: first dout_valid 2 edges after halt_i sampled high; max rate 1 byte / 2 cycles.
//  dout_valid never drops without a handshake; dout_last only with dout_valid.
//  halt_i falling mid-dump: ignored, dump completes.
//  RESET mid-dump (any state incl. SEND with valid high): next edge returns to reset values, byte dropped, no done_o.
//  idx counter width $clog2(DUMP_COUNT+1); DUMP_COUNT=1 sends a single byte with dout_last (no checksum build).
// CONFIGURATION
//  NRISC_DUMP_CHECKSUM_EN defined: SUM state present; one extra trailing byte = 8-bit mod sum of dumped words,
//   dout_last on that byte only. Total bytes = DUMP_COUNT+1.
//  Undefined: no SUM state, no sum register; dout_last on final memory word. Total bytes = DUMP_COUNT.
// STRUCTURE
//  Shared header nrisc_dbg_defs.vh: state encodings (IDLE/READ/SEND/SUM/DONE), default ADDR_W/DATA_W, HALT opcode.
//  One sub-module: nrisc_dump_cksum (clear/accumulate 8-bit sum); instantiated only under NRISC_DUMP_CHECKSUM_EN.
//  Top: FSM, address/index counters, output register.
// TESTING
//  1 Mem[0..4]=05,08,FF,01,0A, ready=1, halt at t0 -> stream 05,08,FF,01,0A; last on 0A; done_o=1; no more valid.
//  2 Same with NRISC_DUMP_CHECKSUM_EN -> 05,08,FF,01,0A,17; last only on 17; 6 handshakes total.
//  3 Backpressure: ready=0 for 3 cycles while 08 offered -> data holds 08, valid stays 1, mem_addr_o stays 01.
//  4 RESET pulse 1 cycle during SEND of byte FF -> valid=0, done_o=0, mem_addr_o=00; halt high re-dumps from 05.
//  5 BASE_ADDR=8'hFE, DUMP_COUNT=4 -> read addresses FE,FF,00,01 in order; last on addr 01 byte.
//  6 halt_i=0 for 100 cycles -> mem_rd_o, dout_valid stay 0; halt toggling after done_o -> no new bytes.

Source files
------------

// File: rtl/nrisc_mem_dump_pkg.sv
// Shared definitions for the nRisc debug memory-dump engine: FSM states,
// default widths and the HALT opcode.
package nrisc_mem_dump_pkg;

  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam logic [7:0]  HALT_OPCODE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND,
    ST_SUM,
    ST_DONE
  } dump_state_t;

endpackage

// File: rtl/nrisc_mem_dump_cksum.sv
// Running modulo-2**DATA_W sum of dumped words; cleared at dump start,
// accumulated once per memory read.
module nrisc_dump_cksum #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_acc,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_sum <= '0;
    end else if (i_acc) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/nrisc_mem_dump.sv
// Halt-triggered data-memory dump over a valid/ready byte stream.
// Define NRISC_DUMP_CHECKSUM_EN to append a trailing checksum byte.
module nrisc_mem_dump
  import nrisc_mem_dump_pkg::*;
#(
  parameter int unsigned        ADDR_W     = DEF_ADDR_W,
  parameter int unsigned        DATA_W     = DEF_DATA_W,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0,
  parameter int unsigned        DUMP_COUNT = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned      IDX_W    = $clog2(DUMP_COUNT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DUMP_COUNT - 1);

  dump_state_t      r_state;
  dump_state_t      w_next;
  logic [IDX_W-1:0] r_idx;
  logic             w_hs;
  logic             w_final;

  assign w_hs    = dout_valid && dout_ready;
  assign w_final = (r_idx == LAST_IDX);

`ifdef NRISC_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] w_sum;

  nrisc_dump_cksum #(.DATA_W(DATA_W)) u_cksum (
    .i_clk  (CLK),
    .i_rst  (RESET),
    .i_clr  ((r_state == ST_IDLE) && halt_i),
    .i_acc  (r_state == ST_READ),
    .i_data (mem_data_i),
    .o_sum  (w_sum)
  );
`endif

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (halt_i) w_next = ST_READ;
      ST_READ: w_next = ST_SEND;
      ST_SEND: begin
        if (w_hs) begin
`ifdef NRISC_DUMP_CHECKSUM_EN
          w_next = w_final ? ST_SUM : ST_READ;
`else
          w_next = w_final ? ST_DONE : ST_READ;
`endif
        end
      end
`ifdef NRISC_DUMP_CHECKSUM_EN
      ST_SUM:  if (w_hs) w_next = ST_DONE;
`endif
      ST_DONE: w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Stream outputs are registered; the checksum byte is loaded on the
  // final word's handshake so SUM presents it without a bubble.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_addr_o <= BASE_ADDR;
      r_idx      <= '0;
      dout_data  <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_READ: begin
          dout_data  <= mem_data_i;
          dout_valid <= 1'b1;
`ifdef NRISC_DUMP_CHECKSUM_EN
          dout_last  <= 1'b0;
`else
          dout_last  <= w_final;
`endif
        end
        ST_SEND: begin
          if (w_hs) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            if (!w_final) begin
              mem_addr_o <= mem_addr_o + 1'b1;
              r_idx      <= r_idx + 1'b1;
            end else begin
`ifdef NRISC_DUMP_CHECKSUM_EN
              dout_data  <= w_sum;
              dout_valid <= 1'b1;
              dout_last  <= 1'b1;
`else
              dout_data  <= '0;
`endif
            end
          end
        end
        ST_SUM: begin
          if (w_hs) begin
            dout_data  <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_rd_o = (r_state == ST_READ);
  assign busy_o   = (r_state == ST_READ) || (r_state == ST_SEND) || (r_state == ST_SUM);
  assign done_o   = (r_state == ST_DONE);

endmodule

// File: tb/tb_nrisc_mem_dump.sv
// Scoreboard bench for nrisc_mem_dump: directed dumps, backpressure, reset
// mid-dump, address wrap, idle/after-done quiet behaviour.
module tb_nrisc_mem_dump;

`ifdef NRISC_DUMP_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET, halt, ready, halt5, ready5;
  logic [7:0] mem [256];

  logic [7:0] addr0, data0, addr5, data5;
  logic       rd0, valid0, last0, busy0, done0;
  logic       rd5, valid5, last5, busy5, done5;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp5_q[$];
  logic [7:0] addr5_q[$];

  always #5 CLK = ~CLK;

  nrisc_mem_dump u_dut (
    .CLK(CLK), .RESET(RESET), .halt_i(halt),
    .mem_addr_o(addr0), .mem_rd_o(rd0), .mem_data_i(mem[addr0]),
    .dout_data(data0), .dout_valid(valid0), .dout_ready(ready),
    .dout_last(last0), .busy_o(busy0), .done_o(done0)
  );

  nrisc_mem_dump #(.BASE_ADDR(8'hFE), .DUMP_COUNT(4)) u_dut5 (
    .CLK(CLK), .RESET(RESET), .halt_i(halt5),
    .mem_addr_o(addr5), .mem_rd_o(rd5), .mem_data_i(mem[addr5]),
    .dout_data(data5), .dout_valid(valid5), .dout_ready(ready5),
    .dout_last(last5), .busy_o(busy5), .done_o(done5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitors: sample between edges; a byte counts when valid&ready and no reset.
  always @(negedge CLK) begin
    if (!RESET && valid0 && ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) chk("unexpected_byte", {last0, data0}, 32'hDEAD);
      else chk("stream_byte", {last0, data0}, exp_q.pop_front());
    end
  end

  always @(negedge CLK) begin
    if (!RESET && valid5 && ready5) begin
      if (exp5_q.size() == 0) chk("unexpected_byte5", {last5, data5}, 32'hDEAD);
      else chk("stream_byte5", {last5, data5}, exp5_q.pop_front());
    end
    if (!RESET && rd5) begin
      if (addr5_q.size() == 0) chk("unexpected_read5", addr5, 32'hDEAD);
      else chk("read_addr5", addr5, addr5_q.pop_front());
    end
  end

  task automatic push_full_dump();
    logic [7:0] v [5];
    v = '{8'h05, 8'h08, 8'hFF, 8'h01, 8'h0A};
    for (int i = 0; i < 5; i++) exp_q.push_back({(!CK && i == 4), v[i]});
    if (CK) exp_q.push_back({1'b1, 8'h17});
  endtask

  task automatic wait_done0(input string name);
    int n;
    n = 0;
    while (!done0 && n < 100) begin
      tick();
      n++;
    end
    chk(name, done0, 1'b1);
  endtask

  initial begin
    int seen;
    logic found;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[0] = 8'h05; mem[1] = 8'h08; mem[2] = 8'hFF; mem[3] = 8'h01; mem[4] = 8'h0A;
    mem[8'hFE] = 8'h33; mem[8'hFF] = 8'h44;

    RESET = 1'b1; halt = 1'b0; ready = 1'b1; halt5 = 1'b0; ready5 = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    chk("rst_addr", addr0, 8'h00);
    chk("rst_rd", rd0, 1'b0);
    chk("rst_valid", valid0, 1'b0);
    chk("rst_last", last0, 1'b0);
    chk("rst_data", data0, 8'h00);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_addr5", addr5, 8'hFE);

    // Quiet while not halted
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rd0 || valid0 || busy0) seen++;
    end
    chk("idle_quiet", seen, 0);

    // Full dump with backpressure on byte 08; halt drops mid-dump
    push_full_dump();
    hs_cnt = 0;
    halt = 1'b1;
    tick();
    chk("lat1_rd", rd0, 1'b1);
    chk("lat1_valid", valid0, 1'b0);
    halt = 1'b0;
    tick();
    chk("lat2_valid", valid0, 1'b1);
    chk("lat2_busy", busy0, 1'b1);
    tick();
    ready = 1'b0;
    chk("bp_addr_read", addr0, 8'h01);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("bp_data", data0, 8'h08);
      chk("bp_valid", valid0, 1'b1);
      chk("bp_addr", addr0, 8'h01);
      tick();
    end
    ready = 1'b1;
    wait_done0("dump1_done");
    chk("dump1_bytes", hs_cnt, 5 + int'(CK));
    chk("dump1_queue", exp_q.size(), 0);
    chk("done_valid", valid0, 1'b0);
    chk("done_data", data0, 8'h00);
    chk("done_busy", busy0, 1'b0);

    // Halt toggling after done must not restart
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      halt = ~halt;
      tick();
      if (valid0 || rd0) seen++;
    end
    chk("after_done_quiet", seen, 0);
    chk("after_done_sticky", done0, 1'b1);
    halt = 1'b0;

    // Reset while FF is offered, then re-dump from the start
    RESET = 1'b1; tick(); RESET = 1'b0;
    exp_q.push_back({1'b0, 8'h05});
    exp_q.push_back({1'b0, 8'h08});
    halt = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (valid0 && data0 == 8'hFF) begin
        ready = 1'b0;
        found = 1'b1;
      end
    end
    chk("rst4_reach_ff", found, 1'b1);
    chk("rst4_queue", exp_q.size(), 0);
    push_full_dump();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    ready = 1'b1;
    chk("rst4_valid", valid0, 1'b0);
    chk("rst4_done", done0, 1'b0);
    chk("rst4_addr", addr0, 8'h00);
    chk("rst4_busy", busy0, 1'b0);
    hs_cnt = 0;
    wait_done0("redump_done");
    halt = 1'b0;
    chk("redump_bytes", hs_cnt, 5 + int'(CK));
    chk("redump_queue", exp_q.size(), 0);

    // Address wrap from FE, four words
    addr5_q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp5_q.push_back({1'b0, 8'h33});
    exp5_q.push_back({1'b0, 8'h44});
    exp5_q.push_back({1'b0, 8'h05});
    exp5_q.push_back({!CK, 8'h08});
    if (CK) exp5_q.push_back({1'b1, 8'h84});
    halt5 = 1'b1;
    seen = 0;
    while (!done5 && seen < 100) begin
      tick();
      seen++;
    end
    chk("wrap_done", done5, 1'b1);
    chk("wrap_queue", exp5_q.size(), 0);
    chk("wrap_addr_queue", addr5_q.size(), 0);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
